store_narrow_buffer: RTL and testbench
======================================

// Module: store_narrow_buffer
// PURPOSE
// - Store-path counterpart of the load-side sign extension: narrows a 32-bit register value to byte/half/word,
//   replicates it onto the correct byte lanes, generates byte enables, and queues it for data memory.
// - Sits between the MEM-stage store request and the data-memory write port.
// - Decouples pipeline from memory stalls via a DEPTH-entry FIFO with valid/ready handshakes on both sides.
// PARAMETERS
// - DEPTH   4   store queue entries (power of 2, >=2)
// - ADDR_W  32  byte address width
// PORTS
// - clk_i         in   1       clock, all state on rising edge
// - rst_i         in   1       asynchronous, active-low reset
// - st_valid_i    in   1       store request valid
// - st_ready_o    out  1       queue can accept a request
// - st_size_i     in   2       00 byte, 01 half, 10 word, 11 illegal
// - st_addr_i     in   ADDR_W  byte address of store
// - st_data_i     in   32      register value (low bits significant for byte/half)
// - mem_valid_o   out  1       head entry valid toward memory
// - mem_ready_i   in   1       memory accepts head this cycle
// - mem_addr_o    out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
// - mem_wdata_o   out  32      lane-replicated write data
// - mem_be_o      out  4       byte enables, bit n = bits [8n+7:8n]
// - misalign_o    out  1       one-cycle pulse: accepted request was misaligned/illegal and dropped
// - count_o       out  $clog2(DEPTH)+1  entries held
// BEHAVIOUR
// - Reset (rst_i=0, async): queue emptied, pointers 0, count_o=0, mem_valid_o=0, misalign_o=0,
//   mem_addr_o/mem_wdata_o/mem_be_o=0, st_ready_o=1 after reset release.
// - Handshake: input accepted on clk edge when st_valid_i && st_ready_o; output retired when mem_valid_o && mem_ready_i.
// - st_ready_o = (count_o < DEPTH); registered-state only, no combinational path from mem_ready_i.
// - Lane encoding (sz, a=addr[1:0]):
//   byte: wdata={4{d[7:0]}}, be=4'b0001<<a; half: wdata={2{d[15:0]}}, be=a[1]?1100:0011, illegal if a[0];
//   word: wdata=d, be=1111, illegal if a!=0; sz=11 always illegal.
// - Illegal accepted request: consumed (handshake completes), NOT enqueued; misalign_o=1 next cycle only.
// - Legal accepted request: enqueued; earliest appearance on mem_valid_o is the next cycle (latency 1, no bypass).
// - mem_valid_o = (count_o != 0); mem_addr_o/wdata/be driven from head entry, stable while mem_valid_o && !mem_ready_i.
// - Order: strict FIFO; stores retire in acceptance order.
// - Simultaneous enqueue+dequeue: count unchanged, both pointers advance; allowed at any non-full count.
// - Full: st_ready_o=0 even if mem_ready_i=1 that cycle; next cycle ready reasserts after dequeue.
// - Empty: mem_ready_i ignored; no pointer movement.
// - Pointer wrap: log2(DEPTH)-bit pointers wrap modulo DEPTH; count tracks occupancy 0..DEPTH.
// - Reset mid-operation: all pending stores discarded immediately; no partial write emitted.
// STRUCTURE
// - Shared package: size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_ILL=2'b11.
// - Sub-module store_lane_encode (combinational): size/addr/data -> wdata, be, illegal.
// - Top holds FIFO storage {addr_word, wdata, be}, wr/rd pointers, count, misalign register.
// TESTING
// - Reset then byte store addr=0x1003 data=0x123456AB -> next cycle mem_valid_o=1, addr=0x1000, wdata=0xABABABAB, be=1000.
// - Half store addr=0x2002 data=0xFFFF8001 -> wdata=0x80018001, be=1100; addr=0x2001 -> misalign_o pulse, count stays 0.
// - Word store addr=0x3004, mem_ready_i=0 for 3 cycles -> outputs held stable; retires on first mem_ready_i=1.
// - Fill 4 stores with mem_ready_i=0 -> st_ready_o=0, count_o=4; then ready=1 + valid=1 -> order preserved, 6 stores wrap pointers.
// - Continuous enqueue+dequeue at count=2 for 8 cycles -> count_o constant 2, all data retired in order.
// - Assert rst_i=0 with 3 entries queued -> mem_valid_o=0, count_o=0 immediately; no further writes after release.

Source files
------------

// File: rtl/store_narrow_buffer_pkg.sv
// Shared definitions for the store narrowing buffer: size encodings and word geometry.
package store_narrow_buffer_pkg;

    // Store size field as presented by the MEM stage
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } st_size_e;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = WORD_W / 8;

    // Byte enables for a halfword: upper or lower pair of lanes
    function automatic logic [BE_W-1:0] half_be(input logic upper);
        return upper ? 4'b1100 : 4'b0011;
    endfunction

endpackage

// File: rtl/store_narrow_buffer_if.sv
// Store-request and data-memory write-port bundle for the store narrowing buffer.
interface store_narrow_buffer_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    // Pipeline side
    logic              st_valid_i;
    logic              st_ready_o;
    logic [1:0]        st_size_i;
    logic [ADDR_W-1:0] st_addr_i;
    logic [31:0]       st_data_i;

    // Memory side
    logic              mem_valid_o;
    logic              mem_ready_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [3:0]        mem_be_o;

    // Status
    logic              misalign_o;
    logic [CNT_W-1:0]  count_o;

    // Pipeline/memory environment driving the buffer
    modport master (
        output st_valid_i, st_size_i, st_addr_i, st_data_i, mem_ready_i,
        input  st_ready_o, mem_valid_o, mem_addr_o, mem_wdata_o, mem_be_o, misalign_o, count_o
    );

    // The buffer itself
    modport slave (
        input  st_valid_i, st_size_i, st_addr_i, st_data_i, mem_ready_i,
        output st_ready_o, mem_valid_o, mem_addr_o, mem_wdata_o, mem_be_o, misalign_o, count_o
    );

endinterface

// File: rtl/store_narrow_buffer_lane.sv
// Combinational lane encoder: replicates narrow store data onto all byte lanes and
// selects the byte enables from size and low address bits; flags misaligned/illegal stores.
module store_lane_encode
    import store_narrow_buffer_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        addr_lo,
    input  logic [WORD_W-1:0] data,
    output logic [WORD_W-1:0] wdata,
    output logic [BE_W-1:0]   be,
    output logic              illegal
);

    st_size_e sz;
    assign sz = st_size_e'(size);

    // Decode size into replicated data, lane enables and legality
    always_comb begin
        wdata   = '0;
        be      = '0;
        illegal = 1'b0;
        unique case (sz)
            SZ_BYTE: begin
                wdata = {4{data[7:0]}};
                be    = 4'b0001 << addr_lo;
            end
            SZ_HALF: begin
                wdata   = {2{data[15:0]}};
                be      = half_be(addr_lo[1]);
                illegal = addr_lo[0];
            end
            SZ_WORD: begin
                wdata   = data;
                be      = 4'b1111;
                illegal = (addr_lo != 2'b00);
            end
            SZ_ILL: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_narrow_buffer.sv
// Store narrowing buffer: encodes MEM-stage stores into lane-replicated word writes and
// queues them in a DEPTH-entry FIFO toward the data-memory write port.
module store_narrow_buffer
    import store_narrow_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    store_narrow_buffer_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [WORD_W-1:0] wdata_q [DEPTH];
    logic [BE_W-1:0]   be_q    [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              misalign_q, misalign_d;

    logic [WORD_W-1:0] enc_wdata;
    logic [BE_W-1:0]   enc_be;
    logic              enc_illegal;
    logic [ADDR_W-1:0] addr_word;

    logic              empty;
    logic              ready;
    logic              accept;
    logic              push;
    logic              pop;

    store_lane_encode u_lane_encode (
        .size    (bus.st_size_i),
        .addr_lo (bus.st_addr_i[1:0]),
        .data    (bus.st_data_i),
        .wdata   (enc_wdata),
        .be      (enc_be),
        .illegal (enc_illegal)
    );

    assign addr_word = {bus.st_addr_i[ADDR_W-1:2], 2'b00};

    // Handshake qualification; ready depends on registered occupancy only
    always_comb begin
        empty  = (count_q == '0);
        ready  = (count_q < CNT_W'(DEPTH));
        accept = bus.st_valid_i && ready;
        // Illegal stores complete the handshake but never enter the queue
        push   = accept && !enc_illegal;
        pop    = !empty && bus.mem_ready_i;
    end

    // Next-state for pointers, occupancy and the misalign pulse
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        misalign_d = accept && enc_illegal;
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    // Queue storage; cleared on reset so the idle memory port shows zeros
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
                be_q[i]    <= '0;
            end
        end else if (push) begin
            addr_q[wr_ptr_q]  <= addr_word;
            wdata_q[wr_ptr_q] <= enc_wdata;
            be_q[wr_ptr_q]    <= enc_be;
        end
    end

    assign bus.st_ready_o  = ready;
    assign bus.mem_valid_o = !empty;
    assign bus.mem_addr_o  = addr_q[rd_ptr_q];
    assign bus.mem_wdata_o = wdata_q[rd_ptr_q];
    assign bus.mem_be_o    = be_q[rd_ptr_q];
    assign bus.misalign_o  = misalign_q;
    assign bus.count_o     = count_q;

endmodule

// File: tb/tb_store_narrow_buffer.sv
// Directed self-checking bench for store_narrow_buffer with a small FIFO reference model.
module tb_store_narrow_buffer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    store_narrow_buffer_if #(.DEPTH(4), .ADDR_W(32)) bus ();

    store_narrow_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          cnt_m = 0;
    logic [31:0] q_addr  [$];
    logic [31:0] q_wdata [$];
    logic [3:0]  q_be    [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock of stimulus with model update; checks outputs before and after the edge
    task automatic tick(input bit v, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input bit mr, input logic [31:0] ew,
                        input logic [3:0] eb, input bit eill, output bit acc);
        bit rdy_m;
        bit mis_m;
        bus.st_valid_i  = v;
        bus.st_size_i   = sz;
        bus.st_addr_i   = a;
        bus.st_data_i   = d;
        bus.mem_ready_i = mr;
        rdy_m = (cnt_m < 4);
        check_eq("st_ready", 32'(bus.st_ready_o), 32'(rdy_m));
        check_eq("mem_valid", 32'(bus.mem_valid_o), 32'(cnt_m != 0));
        if (cnt_m != 0) begin
            check_eq("head_addr", bus.mem_addr_o, q_addr[0]);
            check_eq("head_wdata", bus.mem_wdata_o, q_wdata[0]);
            check_eq("head_be", 32'(bus.mem_be_o), 32'(q_be[0]));
        end
        acc   = v && rdy_m;
        mis_m = acc && eill;
        if (mr && cnt_m != 0) begin
            void'(q_addr.pop_front());
            void'(q_wdata.pop_front());
            void'(q_be.pop_front());
            cnt_m--;
        end
        if (acc && !eill) begin
            q_addr.push_back({a[31:2], 2'b00});
            q_wdata.push_back(ew);
            q_be.push_back(eb);
            cnt_m++;
        end
        step();
        bus.st_valid_i = 1'b0;
        check_eq("count", 32'(bus.count_o), 32'(cnt_m));
        check_eq("misalign", 32'(bus.misalign_o), 32'(mis_m));
    endtask

    task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                         input bit mr, input logic [31:0] ew, input logic [3:0] eb,
                         input bit eill, output bit acc);
        tick(1'b1, sz, a, d, mr, ew, eb, eill, acc);
    endtask

    task automatic idle(input bit mr);
        bit unused_acc;
        tick(1'b0, 2'b00, 32'h0, 32'h0, mr, 32'h0, 4'h0, 1'b0, unused_acc);
    endtask

    task automatic drain();
        for (int i = 0; i < 16 && cnt_m != 0; i++) idle(1'b1);
        check_eq("drain_count", 32'(bus.count_o), 32'h0);
    endtask

    // Wrap-phase vectors: size, address, data, expected wdata, expected be
    logic [1:0]  tv_sz [6] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00};
    logic [31:0] tv_a  [6] = '{32'h5001, 32'h5006, 32'h5008, 32'h500E, 32'h5010, 32'h5014};
    logic [31:0] tv_d  [6] = '{32'h000000C3, 32'h1234BEEF, 32'hCAFEF00D, 32'h00000099,
                               32'h00007A5A, 32'hFFFFFF01};
    logic [31:0] tv_w  [6] = '{32'hC3C3C3C3, 32'hBEEFBEEF, 32'hCAFEF00D, 32'h99999999,
                               32'h7A5A7A5A, 32'h01010101};
    logic [3:0]  tv_be [6] = '{4'b0010, 4'b1100, 4'b1111, 4'b0100, 4'b0011, 4'b0001};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        bus.st_valid_i  = 1'b0;
        bus.st_size_i   = 2'b00;
        bus.st_addr_i   = '0;
        bus.st_data_i   = '0;
        bus.mem_ready_i = 1'b0;

        // Reset state
        step();
        step();
        check_eq("rst_count", 32'(bus.count_o), 32'h0);
        check_eq("rst_mem_valid", 32'(bus.mem_valid_o), 32'h0);
        rst_n = 1'b1;
        step();
        check_eq("rst_ready", 32'(bus.st_ready_o), 32'h1);
        check_eq("rst_misalign", 32'(bus.misalign_o), 32'h0);
        check_eq("rst_addr", bus.mem_addr_o, 32'h0);
        check_eq("rst_wdata", bus.mem_wdata_o, 32'h0);
        check_eq("rst_be", 32'(bus.mem_be_o), 32'h0);

        // Byte store at lane 3
        store(2'b00, 32'h1003, 32'h123456AB, 1'b0, 32'hABABABAB, 4'b1000, 1'b0, acc);
        idle(1'b1);
        idle(1'b0);

        // Upper halfword, then misaligned/illegal stores that must be dropped
        store(2'b01, 32'h2002, 32'hFFFF8001, 1'b0, 32'h80018001, 4'b1100, 1'b0, acc);
        idle(1'b1);
        store(2'b01, 32'h2001, 32'hFFFF8001, 1'b0, 32'h0, 4'h0, 1'b1, acc);
        idle(1'b0);
        store(2'b10, 32'h3002, 32'h11111111, 1'b0, 32'h0, 4'h0, 1'b1, acc);
        store(2'b11, 32'h3000, 32'h22222222, 1'b0, 32'h0, 4'h0, 1'b1, acc);
        idle(1'b0);

        // Word store held under back-pressure for 3 cycles
        store(2'b10, 32'h3004, 32'h0BADF00D, 1'b0, 32'h0BADF00D, 4'b1111, 1'b0, acc);
        for (int i = 0; i < 3; i++) idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Fill to full, then stream with memory ready so pointers wrap
        for (int i = 0; i < 4; i++) begin
            store(2'b10, 32'h4000 + 32'(4 * i), 32'h44440000 + 32'(i), 1'b0,
                  32'h44440000 + 32'(i), 4'b1111, 1'b0, acc);
        end
        check_eq("full_count", 32'(bus.count_o), 32'h4);
        check_eq("full_ready", 32'(bus.st_ready_o), 32'h0);
        for (int k = 0; k < 6; k++) begin
            acc = 1'b0;
            for (int t = 0; t < 8 && !acc; t++) begin
                store(tv_sz[k], tv_a[k], tv_d[k], 1'b1, tv_w[k], tv_be[k], 1'b0, acc);
            end
            if (!acc) check_eq("accept_timeout", 32'h0, 32'h1);
        end
        drain();

        // Steady enqueue+dequeue at occupancy 2
        store(2'b10, 32'h6000, 32'h60000000, 1'b0, 32'h60000000, 4'b1111, 1'b0, acc);
        store(2'b10, 32'h6004, 32'h60000001, 1'b0, 32'h60000001, 4'b1111, 1'b0, acc);
        for (int i = 0; i < 8; i++) begin
            store(2'b10, 32'h6008 + 32'(4 * i), 32'h60000002 + 32'(i), 1'b1,
                  32'h60000002 + 32'(i), 4'b1111, 1'b0, acc);
            check_eq("steady_count", 32'(bus.count_o), 32'h2);
        end
        drain();

        // Asynchronous reset with entries pending
        for (int i = 0; i < 3; i++) begin
            store(2'b00, 32'h7000 + 32'(i), 32'h000000E0 + 32'(i), 1'b0,
                  {4{8'hE0 + 8'(i)}}, 4'b0001 << i, 1'b0, acc);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", 32'(bus.mem_valid_o), 32'h0);
        check_eq("midrst_count", 32'(bus.count_o), 32'h0);
        check_eq("midrst_be", 32'(bus.mem_be_o), 32'h0);
        step();
        rst_n = 1'b1;
        cnt_m = 0;
        q_addr.delete();
        q_wdata.delete();
        q_be.delete();
        for (int i = 0; i < 3; i++) idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
